// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and the register-write opcode set.
`default_nettype none
package cpu_pkg;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_IN    = 4'h1;
  localparam logic [3:0] OP_OUT   = 4'h2;
  localparam logic [3:0] OP_JR    = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_ANDI  = 4'h5;
  localparam logic [3:0] OP_ORI   = 4'h6;
  localparam logic [3:0] OP_LW    = 4'h7;
  localparam logic [3:0] OP_SW    = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_BNE   = 4'hA;
  localparam logic [3:0] OP_J     = 4'hB;
  localparam logic [3:0] OP_JAL   = 4'hC;
  localparam logic [3:0] OP_UNDEF = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_IO_IN  = 3'd3,
    S_IO_OUT = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_ALU, OP_IN, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_counters.sv
// Retired-instruction counter and ack wait counter for the sequencer.
`default_nettype none
module seq_counters #(
  parameter int RET_W  = 16,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire,
  input  logic              wait_inc,
  input  logic              wait_clr,
  output logic [RET_W-1:0]  retired,
  output logic [WAIT_W-1:0] wait_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      retired  <= '0;
      wait_cnt <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      // A state change restarts the wait window even if the new state also waits.
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, optional memory/I/O, writeback.
`default_nettype none
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int RET_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op_code,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             io_in_valid,
  input  logic             io_out_ready,
  input  logic             run,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             io_in_ack,
  output logic             io_out_valid,
  output logic             reg_we,
  output logic             pc_update,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q;
  state_t            nxt;
  logic [3:0]        op_q;
  logic [3:0]        op_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              expired;

  // Waiting means stuck in FETCH or MEM without the matching ack.
  assign waiting = ((state_q == S_FETCH) && !imem_ack) ||
                   ((state_q == S_MEM)   && !dmem_ack);
  assign expired = waiting && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt    = state_q;
    op_nxt = op_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack)     nxt = S_DECODE;
        else if (expired) nxt = S_HALT;
      end
      S_DECODE: begin
        op_nxt = op_code;
        case (op_code)
          OP_LW, OP_SW: nxt = S_MEM;
          OP_IN:        nxt = S_IO_IN;
          OP_OUT:       nxt = S_IO_OUT;
          OP_HLT:       nxt = S_HALT;
          default:      nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)     nxt = S_WB;
        else if (expired) nxt = S_HALT;
      end
      S_IO_IN:  if (io_in_valid)  nxt = S_WB;
      S_IO_OUT: if (io_out_ready) nxt = S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   if (run) nxt = S_WB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      op_q         <= 4'h0;
      illegal      <= 1'b0;
      bus_err      <= 1'b0;
      imem_req     <= 1'b1;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      io_out_valid <= 1'b0;
      reg_we       <= 1'b0;
      pc_update    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q <= nxt;
      op_q    <= op_nxt;
      if ((state_q == S_DECODE) && (op_code == OP_UNDEF)) illegal <= 1'b1;
      if (expired) bus_err <= 1'b1;
      // Moore outputs are registered from the next state so they align with state_q.
      imem_req     <= (nxt == S_FETCH);
      dmem_req     <= (nxt == S_MEM);
      dmem_we      <= (nxt == S_MEM) && (op_nxt == OP_SW);
      io_out_valid <= (nxt == S_IO_OUT);
      reg_we       <= (nxt == S_WB) && writes_reg(op_nxt);
      pc_update    <= (nxt == S_WB);
      halted       <= (nxt == S_HALT);
    end
  end

  assign ir_load   = (state_q == S_FETCH) && imem_ack;
  assign io_in_ack = (state_q == S_IO_IN) && io_in_valid;
  assign state     = state_q;

  seq_counters #(
    .RET_W  (RET_W),
    .WAIT_W (WAIT_W)
  ) u_counters (
    .clk      (clk),
    .rst      (rst),
    .retire   (state_q == S_WB),
    .wait_inc (waiting),
    .wait_clr (nxt != state_q),
    .retired  (retired),
    .wait_cnt (wait_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: main instance plus a short-timeout instance.
`default_nettype none
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, dmem_ack, io_in_valid, io_out_ready, run;
  logic [3:0]  op_code;
  logic        imem_req, ir_load, dmem_req, dmem_we, io_in_ack, io_out_valid;
  logic        reg_we, pc_update, halted, illegal, bus_err;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        rst2, imem_ack2, run2;
  logic        imem_req2, ir_load2, dmem_req2, dmem_we2, io_in_ack2, io_out_valid2;
  logic        reg_we2, pc_update2, halted2, illegal2, bus_err2;
  logic [2:0]  state2;
  logic [15:0] retired2;

  int n_checks = 0;
  int n_errors = 0;

  instr_sequencer #(.RET_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .io_in_valid(io_in_valid), .io_out_ready(io_out_ready), .run(run),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .io_in_ack(io_in_ack), .io_out_valid(io_out_valid), .reg_we(reg_we),
    .pc_update(pc_update), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .state(state), .retired(retired)
  );

  instr_sequencer #(.RET_W(16), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst2), .op_code(4'h0), .imem_ack(imem_ack2), .dmem_ack(1'b0),
    .io_in_valid(1'b0), .io_out_ready(1'b0), .run(run2),
    .imem_req(imem_req2), .ir_load(ir_load2), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
    .io_in_ack(io_in_ack2), .io_out_valid(io_out_valid2), .reg_we(reg_we2),
    .pc_update(pc_update2), .halted(halted2), .illegal(illegal2), .bus_err(bus_err2),
    .state(state2), .retired(retired2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // From a FETCH negedge: present op with ack, pass through DECODE.
  task automatic fetch_decode(input logic [3:0] op);
    op_code  = op;
    imem_ack = 1'b1;
    #1 check("ir_load", ir_load, 1);
    step();
    check("decode", state, 1);
    imem_ack = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_st [9];
    exp_st = '{3'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd0};
    rst = 1; op_code = 0; imem_ack = 0; dmem_ack = 0; io_in_valid = 0;
    io_out_ready = 0; run = 0;
    rst2 = 1; imem_ack2 = 0; run2 = 0;
    step(); step();
    check("rst_state", state, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_outs", {dmem_req, dmem_we, io_out_valid, reg_we, pc_update, halted, illegal, bus_err}, 0);
    check("rst_retired", retired, 0);

    // ALU stream with acks every cycle; run is ignored outside HALT.
    rst = 0; imem_ack = 1; run = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("alu_state", state, exp_st[i]);
      check("alu_pc", pc_update, (exp_st[i] == 3'd5) ? 1 : 0);
      check("alu_rwe", reg_we, (exp_st[i] == 3'd5) ? 1 : 0);
    end
    check("alu_retired", retired, 3);
    run = 0;

    // SW with dmem_ack after four wait cycles.
    fetch_decode(4'h8);
    for (int k = 1; k <= 5; k++) begin
      check("sw_state", state, 2);
      check("sw_req_we", {dmem_req, dmem_we}, 2'b11);
      if (k == 5) dmem_ack = 1;
      step();
    end
    dmem_ack = 0;
    check("sw_wb", state, 5);
    check("sw_rwe", reg_we, 0);
    check("sw_pc", pc_update, 1);
    step();
    check("sw_retired", retired, 4);
    check("sw_req_drop", dmem_req, 0);

    // IN with io_in_valid arriving on the 7th IO_IN cycle.
    fetch_decode(4'h1);
    for (int k = 1; k <= 6; k++) begin
      check("in_wait", {state, io_in_ack}, {3'd3, 1'b0});
      step();
    end
    io_in_valid = 1;
    #1 check("in_ack", io_in_ack, 1);
    step();
    io_in_valid = 0;
    check("in_wb", state, 5);
    check("in_rwe", reg_we, 1);
    #1 check("in_ack_pulse", io_in_ack, 0);
    step();
    check("in_retired", retired, 5);

    // HLT holds until run.
    fetch_decode(4'hF);
    for (int k = 0; k < 20; k++) begin
      check("hlt_hold", {state, halted, imem_req}, {3'd6, 1'b1, 1'b0});
      step();
    end
    check("hlt_retired", retired, 5);
    run = 1;
    step();
    run = 0;
    check("hlt_wb", {state, pc_update, reg_we}, {3'd5, 1'b1, 1'b0});
    step();
    check("hlt_fetch", state, 0);
    check("hlt_retired2", retired, 6);

    // UNDEF executes as NOP and leaves illegal sticky.
    fetch_decode(4'hD);
    check("undef_wb", {state, reg_we, pc_update}, {3'd5, 1'b0, 1'b1});
    check("undef_ill", illegal, 1);
    step();
    fetch_decode(4'h0);
    check("ill_sticky", {state, illegal, reg_we}, {3'd5, 1'b1, 1'b1});
    step();
    check("ill_retired", retired, 8);

    // LW stalled in MEM, then reset mid-operation.
    fetch_decode(4'h7);
    check("lw_mem", {state, dmem_req, dmem_we}, {3'd2, 1'b1, 1'b0});
    rst = 1;
    step();
    check("mid_rst", {state, dmem_req, illegal, reg_we}, {3'd0, 1'b0, 1'b0, 1'b0});
    check("mid_rst_ret", retired, 0);
    rst = 0;

    // Timeout instance: four FETCH wait cycles then bus-error HALT.
    rst2 = 0;
    step(); step(); step();
    check("to_wait3", {state2, bus_err2}, {3'd0, 1'b0});
    step();
    check("to_halt", {state2, bus_err2, halted2, pc_update2}, {3'd6, 1'b1, 1'b1, 1'b0});
    check("to_retired", retired2, 0);
    run2 = 1;
    step();
    run2 = 0;
    check("to_wb", {state2, pc_update2, bus_err2}, {3'd5, 1'b1, 1'b1});
    step();
    check("to_retired2", retired2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencer for the simple microprocessor. It sequences each instruction through fetch, decode, optional memory or I/O, and writeback.
- It takes the 4-bit opcode held in IR and drives memory and I/O handshakes, IR load, register-file write enable and PC advance.
- It sits beside the combinational control-word decoder, which still supplies the datapath mux and ALU selects. This block only gates when those selects take effect.

Parameters:
- RET_W, 16, width of the retired-instruction counter.
- TIMEOUT, 255, maximum number of wait cycles for imem_ack or dmem_ack before the bus-error halt.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- op_code  in  4  opcode field of IR; valid from DECODE onward.
- imem_ack  in  1  instruction memory has returned data.
- dmem_ack  in  1  data memory access has completed.
- io_in_valid  in  1  input port holds data.
- io_out_ready  in  1  output port accepts data.
- run  in  1  resume request from HALT.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  capture instruction into IR.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (SW).
- io_in_ack  out  1  input data consumed.
- io_out_valid  out  1  output data presented.
- reg_we  out  1  register-file write strobe.
- pc_update  out  1  one-cycle PC advance pulse.
- halted  out  1  sequencer is in HALT.
- illegal  out  1  sticky flag: UNDEF opcode seen.
- bus_err  out  1  sticky flag: memory ack timeout.
- state  out  3  current state, for debug.
- retired  out  RET_W  count of retired instructions.

Behaviour:
- Opcode map: 0 ALU, 1 IN, 2 OUT, 3 JR, 4 ADDI, 5 ANDI, 6 ORI, 7 LW, 8 SW, 9 BEQ, A BNE, B J, C JAL, D UNDEF, E NOP, F HLT.
- States: FETCH, DECODE, MEM, IO_IN, IO_OUT, WB, HALT.
- Outputs are Moore decodes of the state register, except ir_load and io_in_ack, which are Mealy as defined below.
- After any clock edge with rst=1:
  - state=FETCH, imem_req=1.
  - retired=0, illegal=0, bus_err=0, wait counter=0, op_q=0.
  - All other outputs 0.
- FETCH:
  - imem_req=1.
  - ir_load = imem_ack (combinational).
  - On imem_ack go to DECODE.
- DECODE (exactly 1 cycle):
  - Latch op_code into op_q. Later changes on op_code are ignored until the next DECODE.
  - Next state by op_q: 7/8 -> MEM; 1 -> IO_IN; 2 -> IO_OUT; F -> HALT; D -> set illegal, then WB (executes as NOP); all others -> WB.
- MEM:
  - dmem_req=1, dmem_we=(op_q==8).
  - On dmem_ack go to WB.
- IO_IN:
  - io_in_ack = io_in_valid.
  - On io_in_valid go to WB.
  - No timeout applies.
- IO_OUT:
  - io_out_valid=1.
  - On io_out_ready go to WB.
  - No timeout applies.
- WB (exactly 1 cycle):
  - pc_update=1.
  - reg_we=1 iff op_q is in {0,1,4,5,6,7,C}.
  - retired increments by 1 and wraps modulo 2^RET_W.
  - Next state is FETCH.
- HALT:
  - halted=1; no bus requests are issued.
  - run=1 -> WB: PC advances past HLT and HLT retires.
  - run asserted in any other state is ignored.
- Timeout:
  - The wait counter clears on every state change.
  - It increments each cycle spent in FETCH without imem_ack, or in MEM without dmem_ack.
  - When it reaches TIMEOUT, the next edge sets bus_err and enters HALT. No pc_update and no retire occur.
  - A run from this HALT re-enters WB (skips the faulting instruction).
- Latency with immediate acks:
  - 3 cycles per instruction (FETCH, DECODE, WB).
  - 4 cycles for LW, SW, IN and OUT.
- Acks arriving in a non-waiting state are ignored.
- Reset in mid-operation (e.g. in MEM): dmem_req drops on the next cycle and no write or retire is committed.
- illegal and bus_err clear only on rst.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams (OP_ALU..OP_HLT);
  - the state enum/localparams (S_FETCH=0..S_HALT=6);
  - the reg_we opcode-set function.
- The retire counter plus timeout counter form a natural sub-module, seq_counters. All other logic stays inline.

Test Plan:
- Reset, then imem_ack=1 every cycle, op_code=0 (ALU) -> state sequence FETCH, DECODE, WB repeating; reg_we and pc_update pulse every 3rd cycle; retired=3 after 9 cycles.
- op_code=8 (SW), dmem_ack delayed 4 cycles -> dmem_req and dmem_we high for 5 cycles; reg_we=0 in WB; retired increments once.
- op_code=1 (IN), io_in_valid raised 6 cycles after IO_IN entry -> io_in_ack is a single-cycle pulse coincident with io_in_valid; reg_we=1 in the next cycle.
- op_code=F (HLT) -> halted=1 holds for 20 cycles with imem_req=0; run pulse -> one WB (pc_update=1, retired+1), then FETCH.
- TIMEOUT=4, imem_ack held 0 -> bus_err=1 and state=HALT after the 4th wait cycle; retired unchanged.
- op_code=D -> illegal=1 stays set across later instructions; WB with reg_we=0; rst asserted in MEM -> state=FETCH and illegal=0.
